// File: rtl/fpu_pkg.sv
// Shared FPU writeback definitions: source indices and the writeback payload
// that every FP sub-unit hands to the writeback arbiter.
package fpu_pkg;

  localparam int NUM_SRC = 4;

  typedef enum logic [1:0] {
    SRC_CLASSIFY = 2'd0,
    SRC_COMPARE  = 2'd1,
    SRC_MINMAX   = 2'd2,
    SRC_CVT      = 2'd3
  } src_idx_e;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        to_int;
    logic [4:0]  fflags;
  } wb_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first requester at or after ptr
// (wrapping) gets a one-hot grant.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_wb_arbiter.sv
// Collects one-cycle result pulses from the FP sub-units into per-source
// holding slots and drains them round-robin through a single writeback register.
module fp_wb_arbiter
  import fpu_pkg::*;
#(
  parameter  int NUM_SRC = fpu_pkg::NUM_SRC,
  localparam int SW      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_SRC-1:0]       i_src_valid,
  input  logic [NUM_SRC-1:0][31:0] i_src_result,
  input  logic [NUM_SRC-1:0][4:0]  i_src_rd,
  input  logic [NUM_SRC-1:0]       i_src_to_int,
  input  logic [NUM_SRC-1:0][4:0]  i_src_fflags,
  output logic [NUM_SRC-1:0]       o_src_stall,
  output logic                     o_wb_valid,
  input  logic                     i_wb_ready,
  output logic [31:0]              o_wb_result,
  output logic [4:0]               o_wb_rd,
  output logic                     o_wb_to_int,
  output logic [4:0]               o_wb_fflags,
  output logic [SW-1:0]            o_wb_src,
  output logic                     o_overflow
);

  logic [NUM_SRC-1:0]      slot_valid;
  wb_entry_t [NUM_SRC-1:0] slot_data;
  wb_entry_t [NUM_SRC-1:0] src_entry;
  logic                    out_valid;
  wb_entry_t               out_data;
  logic [SW-1:0]           out_src;
  logic [SW-1:0]           rr_ptr;
  logic                    overflow;

  logic                    take;
  logic [NUM_SRC-1:0]      arb_grant;
  logic [NUM_SRC-1:0]      grant;
  logic                    grant_any;
  logic [SW-1:0]           gidx;

  always_comb begin
    src_entry = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_entry[i].result = i_src_result[i];
      src_entry[i].rd     = i_src_rd[i];
      src_entry[i].to_int = i_src_to_int[i];
      src_entry[i].fflags = i_src_fflags[i];
    end
  end

  // The output register can take a new entry when empty or draining this cycle.
  assign take = !out_valid || i_wb_ready;

  rr_arbiter #(.N(NUM_SRC)) u_rr_arbiter (
    .req   (slot_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant)
  );

  assign grant     = arb_grant & {NUM_SRC{take}};
  assign grant_any = |grant;

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (arb_grant[i]) gidx = SW'(i);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      slot_valid <= '0;
      slot_data  <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_src    <= '0;
      rr_ptr     <= '0;
      overflow   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (grant[i]) slot_valid[i] <= 1'b0;
        // A slot being granted this cycle may be refilled in the same cycle.
        if (i_src_valid[i]) begin
          if (!slot_valid[i] || grant[i]) begin
            slot_valid[i] <= 1'b1;
            slot_data[i]  <= src_entry[i];
          end else begin
            overflow <= 1'b1;
          end
        end
      end

      if (grant_any) begin
        out_valid <= 1'b1;
        out_data  <= slot_data[gidx];
        out_src   <= gidx;
        rr_ptr    <= (gidx == SW'(NUM_SRC - 1)) ? '0 : gidx + 1'b1;
      end else if (i_wb_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign o_src_stall = slot_valid;
  assign o_wb_valid  = out_valid;
  assign o_wb_result = out_data.result;
  assign o_wb_rd     = out_data.rd;
  assign o_wb_to_int = out_data.to_int;
  assign o_wb_fflags = out_data.fflags;
  assign o_wb_src    = out_src;
  assign o_overflow  = overflow;

endmodule
